// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding, default parameters and line levels for the UART transmitter
package uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_e;
  localparam int DEF_CLKS_PER_BIT = 174;
  localparam int DEF_FIFO_DEPTH = 16;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT = 1'b1;
endpackage

// File: rtl/sync_byte_fifo.sv
// sync_byte_fifo: fall-through byte FIFO; in clk/rst/push/pop/din, out dout/level/full/empty
module sync_byte_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = DEF_FIFO_DEPTH,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  output logic [AW:0] level,
  output logic        full,
  output logic        empty
);
  localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);
  logic [7:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign level = wr_ptr - rd_ptr;
  assign empty = wr_ptr == rd_ptr;
  assign full = level == FULL_LVL;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[rd_ptr[AW-1:0]];
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/uart_byte_tx.sv
// uart_byte_tx: FIFO-buffered 8N1 LSB-first UART sender; in tx_en/tx_data, out tx_ready/uart_txd/busy/fifo_level/overflow
module uart_byte_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int LVL_W = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tx_en,
  input  logic [7:0]       tx_data,
  output logic             tx_ready,
  output logic             uart_txd,
  output logic             busy,
  output logic [LVL_W-1:0] fifo_level,
  output logic             overflow
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);
  localparam logic [LVL_W-1:0] RDY_MAX = LVL_W'(FIFO_DEPTH - 3);
  uart_state_e state, state_nx;
  logic [BW-1:0] baud_cnt;
  logic [2:0] bit_cnt;
  logic [7:0] shift_reg, head;
  logic full, empty, pop, tick, line;
  sync_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(tx_en),
    .pop(pop),
    .din(tx_data),
    .dout(head),
    .level(fifo_level),
    .full(full),
    .empty(empty)
  );
  assign tick = baud_cnt == BAUD_MAX;
  assign busy = state != IDLE || fifo_level != '0;
  always_ff @(posedge clk) state <= rst ? IDLE : state_nx;
  always_comb begin
    state_nx = state;
    pop = 1'b0;
    line = STOP_BIT;
    case (state)
      IDLE: begin
        pop = !empty;
        state_nx = empty ? IDLE : START;
      end
      START: begin
        line = START_BIT;
        state_nx = tick ? DATA : START;
      end
      DATA: begin
        line = shift_reg[0];
        state_nx = tick && bit_cnt == 3'd7 ? STOP : DATA;
      end
      STOP: begin
        pop = tick && !empty;
        state_nx = !tick ? STOP : empty ? IDLE : START;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      baud_cnt <= '0;
      bit_cnt <= '0;
      shift_reg <= '0;
      uart_txd <= STOP_BIT;
      tx_ready <= 1'b0;
      overflow <= 1'b0;
    end else begin
      uart_txd <= line;
      tx_ready <= fifo_level <= RDY_MAX;
      overflow <= overflow | (tx_en & full);
      if (pop) begin
        shift_reg <= head;
        baud_cnt <= '0;
        bit_cnt <= '0;
      end else if (state != IDLE) begin
        baud_cnt <= tick ? '0 : baud_cnt + 1'b1;
        if (state == DATA && tick) begin
          shift_reg <= shift_reg >> 1;
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_uart_byte_tx.sv
// tb_uart_byte_tx: randomized self-checking bench with a UART line decoder as reference
module tb_uart_byte_tx;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;
  int checks = 0, errors = 0;
  logic rst_a = 1'b1, en_a = 1'b0, rdy_a, txd_a, busy_a, ovf_a;
  logic [7:0] data_a = '0;
  logic [4:0] lvl_a;
  logic rst_b = 1'b1, en_b = 1'b0, rdy_b, txd_b, busy_b, ovf_b;
  logic [7:0] data_b = '0;
  logic [2:0] lvl_b;
  uart_byte_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(16)) u_a (
    .clk(clk), .rst(rst_a), .tx_en(en_a), .tx_data(data_a), .tx_ready(rdy_a),
    .uart_txd(txd_a), .busy(busy_a), .fifo_level(lvl_a), .overflow(ovf_a)
  );
  uart_byte_tx #(.CLKS_PER_BIT(2), .FIFO_DEPTH(4)) u_b (
    .clk(clk), .rst(rst_b), .tx_en(en_b), .tx_data(data_b), .tx_ready(rdy_b),
    .uart_txd(txd_b), .busy(busy_b), .fifo_level(lvl_b), .overflow(ovf_b)
  );
  logic [7:0] rx_a[$], rx_b[$];
  int st_a[$];
  int ferr_a = 0, ferr_b = 0;
  task automatic mon(input int d);
    int cpb, t0;
    logic [9:0] f;
    bit abort;
    cpb = d ? 2 : 4;
    forever begin
      @(negedge clk);
      if ((d ? txd_b : txd_a) === 1'b0 && !(d ? rst_b : rst_a)) begin
        t0 = cyc;
        f = '0;
        abort = 0;
        for (int n = 1; n <= 9 * cpb + cpb / 2 && !abort; n++) begin
          @(negedge clk);
          if (d ? rst_b : rst_a) abort = 1;
          else if (n % cpb == cpb / 2) f[n / cpb] = d ? txd_b : txd_a;
        end
        if (!abort) begin
          if (f[0] !== 1'b0 || f[9] !== 1'b1) begin
            if (d) ferr_b++; else ferr_a++;
          end else if (d) rx_b.push_back(f[8:1]);
          else begin
            rx_a.push_back(f[8:1]);
            st_a.push_back(t0);
          end
        end
      end
    end
  endtask
  task automatic wait_rx(input int d, input int n, input int budget);
    int t = 0;
    while ((d ? rx_b.size() : rx_a.size()) < n && t < budget) begin
      @(negedge clk);
      t++;
    end
  endtask
  task automatic test_reset;
    rst_a = 1'b1;
    rst_b = 1'b1;
    en_a = 1'b0;
    en_b = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (txd_a !== 1'b1) begin errors++; $display("FAIL reset_txd got %b want 1", txd_a); end
    checks++; if (rdy_a !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", rdy_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy_a); end
    checks++; if (lvl_a !== 5'd0) begin errors++; $display("FAIL reset_level got %0d want 0", lvl_a); end
    checks++; if (ovf_a !== 1'b0) begin errors++; $display("FAIL reset_ovf_a got %b want 0", ovf_a); end
    checks++; if (ovf_b !== 1'b0) begin errors++; $display("FAIL reset_ovf_b got %b want 0", ovf_b); end
    rst_a = 1'b0;
    rst_b = 1'b0;
    @(negedge clk);
    checks++; if (rdy_a !== 1'b1) begin errors++; $display("FAIL release_ready_a got %b want 1", rdy_a); end
    checks++; if (rdy_b !== 1'b1) begin errors++; $display("FAIL release_ready_b got %b want 1", rdy_b); end
    repeat (3) @(negedge clk);
  endtask
  task automatic test_single;
    logic [7:0] b = 8'hA5;
    int e0, t, j;
    logic exp_bit;
    rx_a.delete();
    @(negedge clk);
    en_a = 1'b1;
    data_a = b;
    @(negedge clk);
    en_a = 1'b0;
    e0 = cyc;
    checks++; if (lvl_a !== 5'd1) begin errors++; $display("FAIL single_level got %0d want 1", lvl_a); end
    t = 0;
    while (txd_a !== 1'b0 && t < 10) begin
      @(negedge clk);
      t++;
    end
    checks++; if (cyc - e0 != 2) begin errors++; $display("FAIL single_latency got %0d want 2", cyc - e0); end
    for (int i = 0; i < 40; i++) begin
      j = i / 4;
      exp_bit = j == 0 ? 1'b0 : j == 9 ? 1'b1 : b[j-1];
      checks++; if (txd_a !== exp_bit) begin errors++; $display("FAIL single_bit[%0d] got %b want %b", i, txd_a, exp_bit); end
      if (i == 38) begin
        checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL single_busy_hold got %b want 1", busy_a); end
      end
      if (i == 39) begin
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL single_busy_drop got %b want 0", busy_a); end
        checks++; if (lvl_a !== 5'd0) begin errors++; $display("FAIL single_level_end got %0d want 0", lvl_a); end
      end
      @(negedge clk);
    end
    checks++; if (txd_a !== 1'b1) begin errors++; $display("FAIL single_idle got %b want 1", txd_a); end
    checks++; if (rx_a.size() != 1 || rx_a[0] !== b) begin errors++; $display("FAIL single_rx got %0d bytes want 1 byte a5", rx_a.size()); end
  endtask
  task automatic test_frame;
    logic [7:0] frame [10] = '{8'hEB, 8'h9C, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    logic [7:0] exp_q[$];
    int idx = 0, g = 0;
    rx_a.delete();
    st_a.delete();
    for (int r = 0; r < 2; r++) for (int k = 0; k < 10; k++) exp_q.push_back(frame[k]);
    while (idx < 20 && g < 2000) begin
      @(negedge clk);
      g++;
      en_a = rdy_a;
      if (rdy_a) begin
        data_a = exp_q[idx];
        idx++;
      end
    end
    @(negedge clk);
    en_a = 1'b0;
    wait_rx(0, 20, 1200);
    checks++; if (rx_a.size() != 20) begin errors++; $display("FAIL frame_count got %0d want 20", rx_a.size()); end
    for (int k = 0; k < 20 && k < rx_a.size(); k++) begin
      checks++; if (rx_a[k] !== exp_q[k]) begin errors++; $display("FAIL frame_byte[%0d] got %h want %h", k, rx_a[k], exp_q[k]); end
    end
    for (int k = 0; k + 1 < st_a.size(); k++) begin
      checks++; if (st_a[k+1] - st_a[k] != 40) begin errors++; $display("FAIL frame_gap[%0d] got %0d want 40", k, st_a[k+1] - st_a[k]); end
    end
    checks++; if (ovf_a !== 1'b0) begin errors++; $display("FAIL frame_ovf got %b want 0", ovf_a); end
    checks++; if (ferr_a != 0) begin errors++; $display("FAIL frame_framing got %0d want 0", ferr_a); end
  endtask
  task automatic test_random;
    logic [7:0] exp_q[$];
    int gap, g;
    rx_a.delete();
    for (int k = 0; k < 24; k++) begin
      exp_q.push_back(8'($urandom));
      gap = $urandom_range(0, 60);
      g = 0;
      @(negedge clk);
      while ((gap > 0 || !rdy_a) && g < 500) begin
        en_a = 1'b0;
        gap--;
        g++;
        @(negedge clk);
      end
      en_a = 1'b1;
      data_a = exp_q[k];
    end
    @(negedge clk);
    en_a = 1'b0;
    wait_rx(0, 24, 1500);
    checks++; if (rx_a.size() != 24) begin errors++; $display("FAIL random_count got %0d want 24", rx_a.size()); end
    for (int k = 0; k < 24 && k < rx_a.size(); k++) begin
      checks++; if (rx_a[k] !== exp_q[k]) begin errors++; $display("FAIL random_byte[%0d] got %h want %h", k, rx_a[k], exp_q[k]); end
    end
    checks++; if (ovf_a !== 1'b0) begin errors++; $display("FAIL random_ovf got %b want 0", ovf_a); end
  endtask
  task automatic test_push_pop;
    logic [7:0] x = 8'($urandom), y = 8'($urandom);
    rx_a.delete();
    @(negedge clk);
    en_a = 1'b1;
    data_a = x;
    @(negedge clk);
    data_a = y;
    checks++; if (lvl_a !== 5'd1) begin errors++; $display("FAIL pushpop_before got %0d want 1", lvl_a); end
    @(negedge clk);
    en_a = 1'b0;
    checks++; if (lvl_a !== 5'd1) begin errors++; $display("FAIL pushpop_level got %0d want 1", lvl_a); end
    wait_rx(0, 2, 200);
    checks++; if (rx_a.size() != 2 || rx_a[0] !== x || rx_a[1] !== y) begin errors++; $display("FAIL pushpop_order got %0d bytes want %h %h", rx_a.size(), x, y); end
  endtask
  task automatic test_reset_mid;
    int e0, lows = 0;
    rx_a.delete();
    @(negedge clk);
    en_a = 1'b1;
    data_a = 8'h3C;
    @(negedge clk);
    e0 = cyc;
    data_a = 8'($urandom);
    @(negedge clk);
    data_a = 8'($urandom);
    @(negedge clk);
    en_a = 1'b0;
    while (cyc < e0 + 19) @(negedge clk);
    checks++; if (txd_a !== 1'b1 || lvl_a !== 5'd2) begin errors++; $display("FAIL midrst_pre got txd %b level %0d want 1 2", txd_a, lvl_a); end
    rst_a = 1'b1;
    @(negedge clk);
    checks++; if (txd_a !== 1'b1) begin errors++; $display("FAIL midrst_txd got %b want 1", txd_a); end
    checks++; if (lvl_a !== 5'd0) begin errors++; $display("FAIL midrst_level got %0d want 0", lvl_a); end
    checks++; if (rdy_a !== 1'b0) begin errors++; $display("FAIL midrst_ready got %b want 0", rdy_a); end
    rst_a = 1'b0;
    @(negedge clk);
    checks++; if (rdy_a !== 1'b1) begin errors++; $display("FAIL midrst_release got %b want 1", rdy_a); end
    for (int i = 0; i < 100; i++) begin
      if (txd_a !== 1'b1) lows++;
      @(negedge clk);
    end
    checks++; if (lows != 0) begin errors++; $display("FAIL midrst_quiet got %0d low cycles want 0", lows); end
    checks++; if (rx_a.size() != 0) begin errors++; $display("FAIL midrst_rx got %0d bytes want 0", rx_a.size()); end
  endtask
  task automatic test_overflow;
    logic [7:0] b [6];
    int lv [6] = '{1, 1, 2, 3, 4, 4};
    logic rd [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic ov [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    rx_b.delete();
    for (int k = 0; k < 6; k++) b[k] = 8'($urandom);
    @(negedge clk);
    en_b = 1'b1;
    data_b = b[0];
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++; if (lvl_b !== 3'(lv[k])) begin errors++; $display("FAIL ovf_level[%0d] got %0d want %0d", k, lvl_b, lv[k]); end
      checks++; if (rdy_b !== rd[k]) begin errors++; $display("FAIL ovf_ready[%0d] got %b want %b", k, rdy_b, rd[k]); end
      checks++; if (ovf_b !== ov[k]) begin errors++; $display("FAIL ovf_flag[%0d] got %b want %b", k, ovf_b, ov[k]); end
      if (k < 5) data_b = b[k+1];
      else en_b = 1'b0;
    end
    wait_rx(1, 5, 300);
    repeat (60) @(negedge clk);
    checks++; if (rx_b.size() != 5) begin errors++; $display("FAIL ovf_count got %0d want 5", rx_b.size()); end
    for (int k = 0; k < 5 && k < rx_b.size(); k++) begin
      checks++; if (rx_b[k] !== b[k]) begin errors++; $display("FAIL ovf_byte[%0d] got %h want %h", k, rx_b[k], b[k]); end
    end
    checks++; if (ovf_b !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", ovf_b); end
    checks++; if (ferr_b != 0) begin errors++; $display("FAIL ovf_framing got %0d want 0", ferr_b); end
  endtask
  task automatic test_zero;
    int t = 0, n = 0;
    rx_b.delete();
    @(negedge clk);
    en_b = 1'b1;
    data_b = 8'h00;
    @(negedge clk);
    en_b = 1'b0;
    while (txd_b !== 1'b0 && t < 10) begin
      @(negedge clk);
      t++;
    end
    while (txd_b === 1'b0 && n < 40) begin
      n++;
      @(negedge clk);
    end
    checks++; if (n != 18) begin errors++; $display("FAIL zero_low got %0d want 18", n); end
    checks++; if (txd_b !== 1'b1) begin errors++; $display("FAIL zero_stop0 got %b want 1", txd_b); end
    @(negedge clk);
    checks++; if (txd_b !== 1'b1) begin errors++; $display("FAIL zero_stop1 got %b want 1", txd_b); end
    wait_rx(1, 1, 20);
    checks++; if (rx_b.size() != 1 || rx_b[0] !== 8'h00) begin errors++; $display("FAIL zero_rx got %0d bytes want 1 byte 00", rx_b.size()); end
    checks++; if (ovf_b !== 1'b1) begin errors++; $display("FAIL zero_ovf_hold got %b want 1", ovf_b); end
  endtask
  initial begin
    fork
      mon(0);
      mon(1);
    join_none
    test_reset;
    test_single;
    test_frame;
    test_random;
    test_push_pop;
    test_reset_mid;
    test_overflow;
    test_zero;
    test_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
